// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared state encoding and command constants for the SR latch driver
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic CMD_CLR = 1'b0;
  localparam logic CMD_SET = 1'b1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// rtl/sr_drv_timer.sv - loadable down-counter with zero flag; saturates at zero
module sr_drv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - timed active-low set/clear pulse driver for a NAND SR latch
// Optional feedback verify built when SR_DRV_VERIFY_EN is defined.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic set_n,
  output logic clr_n,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic done,
  output logic err
);

  localparam int CW = $clog2(max2(PULSE_W, GAP_W) + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  state_t        state, state_d;
  logic          cmd_q, cmd_d;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0] tmr_ld_val, tmr_count;
  logic          done_d, set_n_d, clr_n_d;

  sr_drv_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    cmd_d      = cmd_q;
    tmr_load   = 1'b0;
    tmr_ld_val = '0;
    tmr_dec    = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = PULSE;
          cmd_d      = cmd_set;
          tmr_load   = 1'b1;
          tmr_ld_val = PULSE_LD;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d    = GAP;
          tmr_load   = 1'b1;
          tmr_ld_val = GAP_LD;
          done_d     = (GAP_LD == '0);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
          done_d  = (tmr_count == CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered yet line up with it.
    set_n_d = !((state_d == PULSE) && (cmd_d == CMD_SET));
    clr_n_d = !((state_d == PULSE) && (cmd_d == CMD_CLR));
  end

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= CMD_CLR;
      set_n <= 1'b1;
      clr_n <= 1'b1;
      done  <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      set_n <= set_n_d;
      clr_n <= clr_n_d;
      done  <= done_d;
    end
  end

`ifdef SR_DRV_VERIFY_EN
  logic err_d;
  // Feedback is sampled on the edge that opens the final gap cycle so err lines up with done.
  assign err_d = done_d && ((q_fb != cmd_q) || (q_bar_fb != ~cmd_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ q_bar_fb;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - self-checking bench for sr_latch_driver with a NAND latch model
module tb_sr_latch_driver;

  localparam int PW = 2;
  localparam int GW = 1;
`ifdef SR_DRV_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_set = 1'b0;
  logic force_q0 = 1'b0;
  logic latch_q = 1'b0;
  logic cmd_ready, set_n, clr_n, q_fb, q_bar_fb, done, err;

  int checks = 0;
  int errors = 0;

  sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_set   (cmd_set),
    .cmd_ready (cmd_ready),
    .set_n     (set_n),
    .clr_n     (clr_n),
    .q_fb      (q_fb),
    .q_bar_fb  (q_bar_fb),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural NAND latch: a low input forces its state, both high holds.
  always @(set_n or clr_n) begin
    if (!set_n) latch_q = 1'b1;
    else if (!clr_n) latch_q = 1'b0;
  end
  assign q_fb     = force_q0 ? 1'b0 : latch_q;
  assign q_bar_fb = !latch_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remember when the last command was accepted and derive every output from the cycle offset.
  int cur = 0;
  int acc = 0;
  bit have = 1'b0;
  bit acc_cmd = 1'b0;
  bit acc_bad = 1'b0;
  int done_seen = 0;

  function automatic bit m_ready();
    return !have || ((cur - acc) >= PW + GW + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have = 1'b0;
    end else begin
      if (cmd_valid && m_ready()) begin
        have    = 1'b1;
        acc     = cur;
        acc_cmd = cmd_set;
        acc_bad = force_q0;
      end
      cur++;
    end
  end

  always @(negedge clk) begin
    int d;
    bit lo, e_set, e_clr, e_done, e_err, e_rdy;
    d      = cur - acc;
    lo     = have && (d >= 1) && (d <= PW);
    e_set  = !(lo && acc_cmd);
    e_clr  = !(lo && !acc_cmd);
    e_done = have && (d == PW + GW);
    e_err  = e_done && VERIFY && acc_bad;
    e_rdy  = m_ready();
    chk("cmp_set_n", set_n, e_set);
    chk("cmp_clr_n", clr_n, e_clr);
    chk("cmp_done", done, e_done);
    chk("cmp_err", err, e_err);
    chk("cmp_ready", cmd_ready, e_rdy);
    chk("never_both_low", set_n | clr_n, 1);
    if (done) done_seen++;
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    int d0, last;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_set_n", set_n, 1);
    chk("idle_clr_n", clr_n, 1);

    // Set command with literal timing.
    cmd_valid = 1'b1; cmd_set = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    chk("set_c1_set_n", set_n, 0);
    chk("set_c1_clr_n", clr_n, 1);
    @(negedge clk);
    chk("set_c2_set_n", set_n, 0);
    @(negedge clk);
    chk("set_c3_set_n", set_n, 1);
    chk("set_c3_done", done, 1);
    chk("set_c3_err", err, 0);
    chk("set_latch_q", q_fb, 1);
    @(negedge clk);
    chk("set_c4_ready", cmd_ready, 1);
    chk("set_c4_done", done, 0);

    // Clear on the first ready cycle.
    cmd_valid = 1'b1; cmd_set = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    chk("clr_c1_clr_n", clr_n, 0);
    chk("clr_c1_set_n", set_n, 1);
    @(negedge clk);
    chk("clr_c2_clr_n", clr_n, 0);
    @(negedge clk);
    chk("clr_c3_clr_n", clr_n, 1);
    chk("clr_c3_done", done, 1);
    chk("clr_latch_q", q_fb, 0);
    @(negedge clk);

    // Reset during cycle 1 of a set pulse.
    cmd_valid = 1'b1; cmd_set = 1'b1;
    @(posedge clk);
    #2 cmd_valid = 1'b0;
    chk("rst_pre_set_n", set_n, 0);
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk("rst_async_set_n", set_n, 1);
    chk("rst_async_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_seen - d0, 0);
    chk("rst_ready_after", cmd_ready, 1);

    // Feedback mismatch: latch q held at 0 during a set.
    force_q0 = 1'b1;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mis_done", done, 1);
    chk("mis_err", err, VERIFY);
    @(negedge clk);
    force_q0 = 1'b0;
    @(negedge clk);

    // Back-to-back: valid held high, alternating commands.
    d0 = done_seen;
    last = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_set = (i % 2 == 0);
      wait_ready();
      if (i > 0) chk("b2b_spacing", cur - last, PW + GW + 1);
      last = cur;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_done_count", done_seen - d0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
